// File: rtl/motor_pkg.sv
// ============================================================================
// Module   : motor_pkg
// Brief    : State encoding and command bit layout shared by the motor
//            command sequencer and the downstream PWM stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package motor_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;

    localparam int CMD_EN  = 0;
    localparam int CMD_DIR = 1;
    localparam int CMD_SPD = 2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DEAD = DEAD
    } state_t;

    function automatic logic [2:0] pack_cmd(input logic spd, input logic dir, input logic en);
        logic [2:0] c;
        c          = '0;
        c[CMD_SPD] = spd;
        c[CMD_DIR] = dir;
        c[CMD_EN]  = en;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module   : sw_debounce
// Brief    : One-bit two-flop synchronizer followed by a consecutive-mismatch
//            debounce counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sw_debounce
    import motor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_dout;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // A single agreeing sample restarts the stability window.
            if (r_sync2 != r_dout) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_dout <= ~r_dout;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + c_CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/motor_cmd_seq.sv
// ============================================================================
// Module   : motor_cmd_seq
// Brief    : Debounces the raw motor switches and sequences them so that any
//            stop or reversal passes through a forced-off dead time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module motor_cmd_seq
    import motor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEAD_CYCLES     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    output logic [2:0] cmd,
    output logic       busy
);

    localparam int                 c_DEAD_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [c_DEAD_W-1:0] c_DEAD_ONE  = c_DEAD_W'(1);

    logic [2:0]          w_deb;
    logic                w_deb_en;
    logic                w_deb_dir;
    logic                w_deb_spd;

    state_t              r_state;
    logic [c_DEAD_W-1:0] r_dead_cnt;
    logic                r_cur_dir;
    logic [2:0]          r_cmd;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [c_DEAD_W-1:0] w_dead_cnt_nxt;
    logic                w_cur_dir_nxt;
    logic [2:0]          w_cmd_nxt;
    logic                w_busy_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            sw_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .din  (sw_raw[gi]),
                .dout (w_deb[gi])
            );
        end
    endgenerate

    assign w_deb_en  = w_deb[CMD_EN];
    assign w_deb_dir = w_deb[CMD_DIR];
    assign w_deb_spd = w_deb[CMD_SPD];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dead_cnt <= '0;
            r_cur_dir  <= 1'b0;
            r_cmd      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
            r_cur_dir  <= w_cur_dir_nxt;
            r_cmd      <= w_cmd_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Outputs are computed for the state being entered, so cmd/busy change
    // on the same edge as the state register.
    always_comb begin
        w_state_nxt    = r_state;
        w_dead_cnt_nxt = r_dead_cnt;
        w_cur_dir_nxt  = r_cur_dir;
        w_cmd_nxt      = pack_cmd(1'b0, r_cur_dir, 1'b0);
        w_busy_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_deb_en) begin
                    w_state_nxt   = ST_RUN;
                    w_cur_dir_nxt = w_deb_dir;
                    w_cmd_nxt     = pack_cmd(w_deb_spd, w_deb_dir, 1'b1);
                end
            end

            ST_RUN: begin
                if (!w_deb_en || (w_deb_dir != r_cur_dir)) begin
                    w_state_nxt    = ST_DEAD;
                    w_dead_cnt_nxt = '0;
                    w_busy_nxt     = 1'b1;
                end else begin
                    w_cmd_nxt = pack_cmd(w_deb_spd, r_cur_dir, 1'b1);
                end
            end

            ST_DEAD: begin
                // Only the debounced inputs present at exit decide the outcome.
                if (r_dead_cnt == c_DEAD_LAST) begin
                    if (w_deb_en) begin
                        w_state_nxt   = ST_RUN;
                        w_cur_dir_nxt = w_deb_dir;
                        w_cmd_nxt     = pack_cmd(w_deb_spd, w_deb_dir, 1'b1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt + c_DEAD_ONE;
                    w_busy_nxt     = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cmd  = r_cmd;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_seq.sv
// ============================================================================
// Module   : tb_motor_cmd_seq
// Brief    : Directed vector table plus randomized switch activity against a
//            cycle-level behavioural model of motor_cmd_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_motor_cmd_seq;

    localparam int DEB   = 4;
    localparam int DEADC = 5;
    localparam int NTBL  = 35;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw_raw;
    logic [2:0] cmd;
    logic       busy;

    always #5 clk = ~clk;

    motor_cmd_seq #(
        .DEBOUNCE_CYCLES (DEB),
        .DEAD_CYCLES     (DEADC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .cmd    (cmd),
        .busy   (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [2:0] m_s1, m_s2, m_deb;
    logic [2:0] m_hist[$];
    int         m_mode;
    int         m_left;
    logic       m_dir;
    logic [2:0] m_cmd;
    logic       m_busy;

    typedef struct {
        logic       r;
        logic [2:0] raw;
        int         cyc;
        logic [2:0] ecmd;
        logic       ebusy;
    } vec_t;

    vec_t tbl [NTBL];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0;
        m_hist.delete();
        m_mode = M_IDLE; m_left = 0; m_dir = 1'b0;
        m_cmd = '0; m_busy = 1'b0;
    endtask

    // One rising edge: FSM sees the old debounced values, debouncers see
    // the old synchronized values, synchronizer samples the raw input.
    task automatic model_edge(input logic r, input logic [2:0] raw);
        logic en, dir, spd;
        bit   flip;
        if (r) begin
            model_reset();
            return;
        end
        en = m_deb[0]; dir = m_deb[1]; spd = m_deb[2];
        m_busy = 1'b0;
        m_cmd  = {1'b0, m_dir, 1'b0};
        case (m_mode)
            M_IDLE: begin
                if (en) begin
                    m_mode = M_RUN; m_dir = dir; m_cmd = {spd, dir, 1'b1};
                end
            end
            M_RUN: begin
                if (!en || dir != m_dir) begin
                    m_mode = M_DEAD; m_left = DEADC; m_busy = 1'b1;
                end else begin
                    m_cmd = {spd, m_dir, 1'b1};
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (en) begin
                        m_mode = M_RUN; m_dir = dir; m_cmd = {spd, dir, 1'b1};
                    end else begin
                        m_mode = M_IDLE;
                    end
                end else begin
                    m_busy = 1'b1;
                end
            end
        endcase
        // A bit flips once the last DEB synchronized samples all disagree.
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (m_hist[i][b] == m_deb[b]) flip = 1'b0;
                if (flip) m_deb[b] = ~m_deb[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check(input string name, input logic [2:0] ecmd, input logic ebusy);
        n_vec++;
        if (cmd !== ecmd || busy !== ebusy) begin
            n_bad++;
            $display("FAIL %s: got cmd=%b busy=%b, expected cmd=%b busy=%b",
                     name, cmd, busy, ecmd, ebusy);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] raw, input string name);
        rst    = r;
        sw_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        @(negedge clk);
        check(name, m_cmd, m_busy);
    endtask

    initial begin
        // rst, raw, cycles held, expected cmd, expected busy after the hold
        tbl = '{
            '{1'b1, 3'b111,  1, 3'b000, 1'b0},   // reset with all switches on
            '{1'b1, 3'b111,  2, 3'b000, 1'b0},
            '{1'b0, 3'b111,  6, 3'b000, 1'b0},   // still quiet 6 after release
            '{1'b0, 3'b111,  1, 3'b111, 1'b0},   // responds 7 after release
            '{1'b1, 3'b000,  1, 3'b000, 1'b0},
            '{1'b0, 3'b000,  3, 3'b000, 1'b0},
            '{1'b0, 3'b001,  6, 3'b000, 1'b0},   // start
            '{1'b0, 3'b001,  1, 3'b001, 1'b0},
            '{1'b0, 3'b101,  6, 3'b001, 1'b0},   // speed up, no dead time
            '{1'b0, 3'b101,  1, 3'b101, 1'b0},
            '{1'b0, 3'b001,  7, 3'b001, 1'b0},   // speed down
            '{1'b0, 3'b011,  6, 3'b001, 1'b0},   // reversal
            '{1'b0, 3'b011,  1, 3'b000, 1'b1},
            '{1'b0, 3'b011,  4, 3'b000, 1'b1},
            '{1'b0, 3'b011,  1, 3'b011, 1'b0},
            '{1'b0, 3'b000,  7, 3'b010, 1'b1},   // stop, dir held during dead
            '{1'b0, 3'b010,  2, 3'b010, 1'b1},   // direction churn mid-dead
            '{1'b0, 3'b000,  2, 3'b010, 1'b1},
            '{1'b0, 3'b000,  1, 3'b010, 1'b0},   // idle with old dir
            '{1'b0, 3'b001,  6, 3'b010, 1'b0},
            '{1'b0, 3'b001,  1, 3'b001, 1'b0},   // re-enable reloads dir
            '{1'b0, 3'b011,  7, 3'b000, 1'b1},   // dead cycle 1
            '{1'b0, 3'b011,  1, 3'b000, 1'b1},   // dead cycle 2
            '{1'b1, 3'b011,  1, 3'b000, 1'b0},   // reset mid-dead
            '{1'b0, 3'b011,  6, 3'b000, 1'b0},
            '{1'b0, 3'b011,  1, 3'b011, 1'b0},
            '{1'b0, 3'b000,  7, 3'b010, 1'b1},
            '{1'b0, 3'b000,  5, 3'b010, 1'b0},
            '{1'b0, 3'b001,  3, 3'b010, 1'b0},   // 3-cycle glitch
            '{1'b0, 3'b000,  1, 3'b010, 1'b0},
            '{1'b0, 3'b001,  3, 3'b010, 1'b0},   // second glitch, counter cleared
            '{1'b0, 3'b000,  8, 3'b010, 1'b0},
            '{1'b0, 3'b001,  4, 3'b010, 1'b0},   // 4-cycle pulse is accepted
            '{1'b0, 3'b000,  3, 3'b001, 1'b0},
            '{1'b0, 3'b000, 12, 3'b000, 1'b0}
        };

        rst    = 1'b1;
        sw_raw = 3'b000;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < NTBL; i++) begin
            for (int k = 0; k < tbl[i].cyc; k++)
                step(tbl[i].r, tbl[i].raw, $sformatf("model_t%0d", i));
            check($sformatf("table_%0d", i), tbl[i].ecmd, tbl[i].ebusy);
        end

        // Randomized switch activity with occasional resets
        for (int s = 0; s < 300; s++) begin
            logic [2:0] raw;
            int         hold;
            raw  = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 14);
            if ($urandom_range(0, 39) == 0)
                step(1'b1, raw, "rand_rst");
            for (int k = 0; k < hold; k++)
                step(1'b0, raw, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/motor_cmd_seq.md
# motor_cmd_seq

Command conditioner that sits directly upstream of the PWM motor stage and drives its 3-bit `switch` input. It synchronizes and debounces the three raw board switches (enable, direction, speed), then sequences them through a state machine. A direction reversal or a restart never reaches the driver without first passing a forced-off dead time, which protects the H-bridge from shoot-through and back-EMF reversal.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a switch change is accepted (≥1).
- `DEAD_CYCLES`, default 20: forced-off cycles after any run-to-stop or reversal (≥1).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sw_raw`  input  3  asynchronous raw switches: [0] enable, [1] direction (1 = reverse), [2] speed (1 = high duty).
- `cmd`  output  3  conditioned command to the PWM stage, same bit meaning as `sw_raw`; registered.
- `busy`  output  1  high while in dead time; registered.

## Operation
- **Per-bit front end.**
  - Two-flop synchronizer.
  - Debounce counter compares the synchronized bit with the debounced value.
  - On mismatch the counter increments. On the DEBOUNCE_CYCLES-th consecutive mismatch the debounced value flips and the counter clears.
  - Any match clears the counter.
- **Debounced signals:** `deb_en`, `deb_dir`, `deb_spd`. The internal `cur_dir` register holds the direction currently applied.
- **IDLE:**
  - `cmd` = {0, cur_dir, 0}, `busy` = 0.
  - If `deb_en`: load `cur_dir` ← `deb_dir`, go to RUN.
- **RUN:**
  - `cmd` = {deb_spd, cur_dir, 1}, `busy` = 0.
  - If `!deb_en` or `deb_dir != cur_dir`: go to DEAD and clear the dead counter.
  - Speed changes pass through immediately, with no dead time.
- **DEAD:**
  - `cmd` = {0, cur_dir, 0}, `busy` = 1. Direction is held at the old value.
  - The counter increments each cycle.
  - On the cycle the counter reaches DEAD_CYCLES-1:
    - if `deb_en`, load `cur_dir` ← `deb_dir` and go to RUN;
    - otherwise go to IDLE.
- **Boundaries:**
  - A raw glitch shorter than DEBOUNCE_CYCLES cycles is ignored entirely.
  - Enable drop and direction change in the same cycle: single DEAD, then IDLE.
  - Direction toggling or enable re-assertion during DEAD does not restart the counter; only the values present at DEAD exit matter.
  - Reversal with enable held: one DEAD pass, exit straight to RUN with the new direction.
  - Counter widths are $clog2(N+1). Counters saturate/clear, never wrap.
- **Reset (any cycle, including mid-DEAD):**
  - Synchronizers, debounced values, counters and `cur_dir` = 0.
  - State = IDLE.
  - `cmd` = 3'b000, `busy` = 0 on the following cycle.

## Timing
- `cmd` and `busy` update on the same edge as the state register and reflect the new state.
- Raw change at edge 0 (stable thereafter):
  - synchronized at edge 2;
  - debounced value flips at edge 2+DEBOUNCE_CYCLES;
  - `cmd` responds at edge 3+DEBOUNCE_CYCLES.
- Reversal while running:
  - `cmd[0]` falls on the DEAD-entry edge E;
  - `cmd[0]` stays low for exactly DEAD_CYCLES cycles;
  - `cmd[0]` returns high with `cmd[1]` flipped at edge E+DEAD_CYCLES.
- `busy` is high for exactly DEAD_CYCLES cycles per DEAD pass.
- No combinational path from `sw_raw` to any output.

## Structure
- **Package `motor_pkg`:**
  - state encoding localparams (IDLE, RUN, DEAD);
  - cmd bit indices CMD_EN=0, CMD_DIR=1, CMD_SPD=2.
  - This package is shared with the PWM stage.
- **Sub-module `sw_debounce`:**
  - one bit: synchronizer plus debounce counter;
  - parameter DEBOUNCE_CYCLES, ports `clk`, `rst`, `din`, `dout`;
  - instantiated three times.
- The FSM, dead counter and `cur_dir` live in `motor_cmd_seq`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and DEAD_CYCLES=5.
- **Reset:** assert `rst` with `sw_raw`=3'b111 → `cmd`=000 and `busy`=0 one cycle later; outputs stay 000 until 7 cycles after release.
- **Start:** `sw_raw` 000→001 at edge 0 → `cmd`=001 at edge 7. Then `sw_raw`=101 → `cmd`=101 7 cycles later with no `busy` pulse.
- **Glitch:** 3-cycle pulse of `sw_raw[0]` → `cmd` stays 000 and the debounce counter returns to 0. A 4-cycle pulse → `cmd[0]` rises.
- **Reversal:** running at 001, set `sw_raw`=011 → `cmd` 001→000 with `busy`=1 for exactly 5 cycles, then `cmd`=011.
- **Stop with direction churn:** running at 011, set `sw_raw`=000, then toggle `sw_raw[1]` mid-dead-time → one 5-cycle DEAD, then IDLE with `cmd`=010. Re-enable with `sw_raw`=001 → `cmd`=001 (enters RUN, `cur_dir` reloaded to 0).
- **Reset mid-DEAD:** assert `rst` on dead cycle 2 → next cycle `cmd`=000, `busy`=0, state IDLE. With enable still held, `cmd[0]` returns 7 cycles after release.
